// File: rtl/cpu_run_pkg.sv
// ---------------------------------------------------------------------------
// cpu_run_pkg : state encoding and stop-cause codes for the run controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_run_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [ST_W-1:0] ST_FLUSH = 3'd2;
    localparam logic [ST_W-1:0] ST_RUN   = 3'd3;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd5;

    typedef logic [1:0] stop_cause_t;

    localparam stop_cause_t SC_NONE = 2'd0;
    localparam stop_cause_t SC_QUIT = 2'd1;
    localparam stop_cause_t SC_HALT = 2'd2;
    localparam stop_cause_t SC_WDOG = 2'd3;

    // Monitor quit beats a CPU halt, which beats a watchdog expiry.
    function automatic stop_cause_t sel_cause(input logic quit, input logic halt,
                                              input logic wdog);
        stop_cause_t c;
        c = SC_NONE;
        if (quit)
            c = SC_QUIT;
        else if (halt)
            c = SC_HALT;
        else if (wdog)
            c = SC_WDOG;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if : monitor/CPU side signals of the run controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cpu_run_ctrl_if;

    logic        cpu_start;
    logic        quit_cmd;
    logic [29:0] start_adr;
    logic        cpu_halt_req;
    logic [31:0] pc_data;
    logic        wdog_en;

    logic        cpu_run;
    logic        pc_set;
    logic [29:0] pc_set_adr;
    logic        mon_lock;
    logic        run_done;
    logic [1:0]  stop_cause;
    logic [31:0] stop_pc;
    logic [31:0] cycle_cnt;

    modport master (
        output cpu_start, quit_cmd, start_adr, cpu_halt_req, pc_data, wdog_en,
        input  cpu_run, pc_set, pc_set_adr, mon_lock, run_done, stop_cause,
               stop_pc, cycle_cnt
    );

    modport slave (
        input  cpu_start, quit_cmd, start_adr, cpu_halt_req, pc_data, wdog_en,
        output cpu_run, pc_set, pc_set_adr, mon_lock, run_done, stop_cause,
               stop_pc, cycle_cnt
    );

endinterface

`default_nettype wire

// File: rtl/run_wdog.sv
// ---------------------------------------------------------------------------
// run_wdog : run-cycle watchdog, flags the cycle the counter reaches all-ones
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module run_wdog #(
    parameter int WDOG_W = 24
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic en,
    output logic      expire
);

    localparam logic [WDOG_W-1:0] ALL_ONES = '1;

    logic [WDOG_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en && (r_cnt != ALL_ONES))
            r_cnt <= r_cnt + 1'b1;
    end

    // Raised in the counting cycle whose increment lands on all-ones, so the
    // run ends after exactly 2^WDOG_W-1 enabled cycles.
    assign expire = en && (r_cnt == (ALL_ONES - 1'b1));

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl : load PC -> flush -> run -> drain -> done run sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int FLUSH_CYC = 3,
    parameter int DRAIN_CYC = 4,
    parameter int WDOG_W    = 24
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    cpu_run_ctrl_if.slave bus
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC - 1);

    logic [ST_W-1:0]  r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cpu_run;
    logic             r_pc_set;
    logic [29:0]      r_pc_set_adr;
    logic             r_run_done;
    stop_cause_t      r_stop_cause;
    logic [31:0]      r_stop_pc;
    logic [31:0]      r_cycle_cnt;

    logic w_accept;
    logic w_wdog_en;
    logic w_wdog_clr;
    logic w_expire;
    logic w_run_exit;

    assign w_accept   = (r_state == ST_IDLE) && bus.cpu_start && !bus.quit_cmd;
    assign w_wdog_clr = (r_state == ST_LOAD);
    assign w_wdog_en  = (r_state == ST_RUN) && bus.wdog_en;
    assign w_run_exit = bus.quit_cmd || bus.cpu_halt_req || w_expire;

    run_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_wdog_clr),
        .en     (w_wdog_en),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cpu_run    <= 1'b0;
            r_pc_set     <= 1'b0;
            r_pc_set_adr <= '0;
            r_run_done   <= 1'b0;
            r_stop_cause <= SC_NONE;
            r_stop_pc    <= '0;
            r_cycle_cnt  <= '0;
        end else begin
            r_pc_set   <= 1'b0;
            r_run_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_LOAD;
                        r_pc_set     <= 1'b1;
                        r_pc_set_adr <= bus.start_adr;
                        r_cycle_cnt  <= '0;
                        r_stop_cause <= SC_NONE;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_FLUSH;
                    r_cnt   <= FLUSH_LD;
                end
                ST_FLUSH: begin
                    if (bus.quit_cmd) begin
                        r_state      <= ST_DRAIN;
                        r_stop_cause <= SC_QUIT;
                        r_cnt        <= DRAIN_LD;
                    end else if (r_cnt == '0) begin
                        r_state   <= ST_RUN;
                        r_cpu_run <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    // The exit cycle itself is a run cycle and is counted.
                    if (r_cycle_cnt != 32'hFFFF_FFFF)
                        r_cycle_cnt <= r_cycle_cnt + 32'd1;
                    if (w_run_exit) begin
                        r_state      <= ST_DRAIN;
                        r_cpu_run    <= 1'b0;
                        r_cnt        <= DRAIN_LD;
                        r_stop_cause <= sel_cause(bus.quit_cmd, bus.cpu_halt_req, w_expire);
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_DONE;
                        r_stop_pc  <= bus.pc_data;
                        r_run_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cpu_run <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_run    = r_cpu_run;
    assign bus.pc_set     = r_pc_set;
    assign bus.pc_set_adr = r_pc_set_adr;
    assign bus.run_done   = r_run_done;
    assign bus.stop_cause = r_stop_cause;
    assign bus.stop_pc    = r_stop_pc;
    assign bus.cycle_cnt  = r_cycle_cnt;
    assign bus.mon_lock   = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl : scenario bench for cpu_run_ctrl with a timeline model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_run_ctrl;

    localparam int FL      = 3;
    localparam int DR      = 4;
    localparam int WW      = 4;
    localparam int WD_RUNS = (1 << WW) - 1;
    localparam int RUN0    = FL + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(
        .FLUSH_CYC (FL),
        .DRAIN_CYC (DR),
        .WDOG_W    (WW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] pc_hist [0:511];
    logic [29:0] last_adr   = '0;
    logic [1:0]  last_cause = 2'd0;

    task automatic quiet_inputs();
        bus.cpu_start    = 1'b0;
        bus.quit_cmd     = 1'b0;
        bus.start_adr    = '0;
        bus.cpu_halt_req = 1'b0;
        bus.wdog_en      = 1'b0;
        bus.pc_data      = $urandom;
    endtask

    // Timeline: input cycle 0 carries the start, 1 is LOAD, 2..FL+1 FLUSH,
    // RUN from RUN0. Returns the last RUN (or FLUSH) cycle and the run length.
    function automatic void model_exit(input int quit_t, input int halt_t, input bit wen,
                                       output int exit_t, output int n, output logic [1:0] cause);
        exit_t = -1;
        n      = 0;
        cause  = 2'd0;
        if (quit_t >= 2 && quit_t <= FL + 1) begin
            exit_t = quit_t;
            cause  = 2'd1;
            return;
        end
        for (int r = 1; r <= 400; r++) begin
            int  t;
            bit  q, h, w;
            t = RUN0 + r - 1;
            q = (quit_t == t);
            h = (halt_t >= 0) && (t >= halt_t);
            w = wen && (r == WD_RUNS);
            if (q || h || w) begin
                exit_t = t;
                n      = r;
                cause  = q ? 2'd1 : (h ? 2'd2 : 2'd3);
                return;
            end
        end
    endfunction

    task automatic run_scenario(input string name, input logic [29:0] adr, input int quit_t,
                                input int halt_t, input bit wen, input int xs_in);
        int         exit_t, n, xs_t;
        logic [1:0] cause;
        model_exit(quit_t, halt_t, wen, exit_t, n, cause);
        if (exit_t < 0) begin
            checks++;
            errors++;
            $display("FAIL %s model: no exit within bound", name);
            return;
        end
        xs_t = (xs_in == -2) ? int'($urandom_range(1, exit_t + DR + 1)) : xs_in;
        for (int t = 0; t <= exit_t + DR + 1; t++) begin
            int o, e_cnt;
            bit e_pcset, e_run, e_lock, e_done;
            bus.cpu_start    = (t == 0) || (t == xs_t);
            bus.start_adr    = (t == 0) ? adr : ~adr;
            bus.quit_cmd     = (t == quit_t);
            bus.cpu_halt_req = (halt_t >= 0) && (t >= halt_t);
            bus.wdog_en      = wen;
            pc_hist[t]       = $urandom;
            bus.pc_data      = pc_hist[t];
            @(posedge clk);
            #1;
            o       = t + 1;
            e_pcset = (o == 1);
            e_run   = (n > 0) && (o >= RUN0) && (o <= exit_t);
            e_lock  = (o >= 1) && (o <= exit_t + DR + 1);
            e_done  = (o == exit_t + DR + 1);
            e_cnt   = (((t < exit_t) ? t : exit_t) - RUN0 + 1);
            if (e_cnt < 0 || n == 0) e_cnt = 0;
            checks += 5;
            if (bus.pc_set !== e_pcset) begin
                errors++;
                $display("FAIL %s pc_set cyc=%0d got=%0b exp=%0b", name, o, bus.pc_set, e_pcset);
            end
            if (bus.cpu_run !== e_run) begin
                errors++;
                $display("FAIL %s cpu_run cyc=%0d got=%0b exp=%0b", name, o, bus.cpu_run, e_run);
            end
            if (bus.mon_lock !== e_lock) begin
                errors++;
                $display("FAIL %s mon_lock cyc=%0d got=%0b exp=%0b", name, o, bus.mon_lock, e_lock);
            end
            if (bus.run_done !== e_done) begin
                errors++;
                $display("FAIL %s run_done cyc=%0d got=%0b exp=%0b", name, o, bus.run_done, e_done);
            end
            if (bus.cycle_cnt !== 32'(e_cnt)) begin
                errors++;
                $display("FAIL %s cycle_cnt cyc=%0d got=%0d exp=%0d", name, o, bus.cycle_cnt, e_cnt);
            end
        end
        quiet_inputs();
        checks += 4;
        if (bus.pc_set_adr !== adr) begin
            errors++;
            $display("FAIL %s pc_set_adr got=%h exp=%h", name, bus.pc_set_adr, adr);
        end
        if (bus.stop_cause !== cause) begin
            errors++;
            $display("FAIL %s stop_cause got=%0d exp=%0d", name, bus.stop_cause, cause);
        end
        if (bus.cycle_cnt !== 32'(n)) begin
            errors++;
            $display("FAIL %s final cycle_cnt got=%0d exp=%0d", name, bus.cycle_cnt, n);
        end
        if (bus.stop_pc !== pc_hist[exit_t + DR]) begin
            errors++;
            $display("FAIL %s stop_pc got=%h exp=%h", name, bus.stop_pc, pc_hist[exit_t + DR]);
        end
        last_adr   = adr;
        last_cause = cause;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.cpu_run !== 1'b0 || bus.pc_set !== 1'b0 || bus.pc_set_adr !== 30'd0 ||
            bus.mon_lock !== 1'b0 || bus.run_done !== 1'b0 || bus.stop_cause !== 2'd0 ||
            bus.stop_pc !== 32'd0 || bus.cycle_cnt !== 32'd0) begin
            errors++;
            $display("FAIL %s outputs got run=%0b set=%0b adr=%h lock=%0b done=%0b sc=%0d pc=%h cnt=%0d exp all zero",
                     name, bus.cpu_run, bus.pc_set, bus.pc_set_adr, bus.mon_lock, bus.run_done,
                     bus.stop_cause, bus.stop_pc, bus.cycle_cnt);
        end
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_halt();
        run_scenario("halt10", 30'h40, -1, RUN0 + 9, 1'b0, -1);
    endtask

    task automatic test_quit_run();
        run_scenario("quit_run5", 30'h1234, -1 + RUN0 + 5, -1, 1'b0, -1);
    endtask

    task automatic test_watchdog();
        run_scenario("wdog_on", 30'h2ABC, -1, -1, 1'b1, -1);
        run_scenario("wdog_off", 30'h0777, RUN0 + 19, -1, 1'b0, -1);
    endtask

    task automatic test_start_quit_idle();
        bus.cpu_start = 1'b1;
        bus.quit_cmd  = 1'b1;
        bus.start_adr = 30'h155;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            quiet_inputs();
            if (i == 1) bus.quit_cmd = 1'b1;
            checks++;
            if (bus.pc_set !== 1'b0 || bus.mon_lock !== 1'b0) begin
                errors++;
                $display("FAIL idle_start_quit cyc=%0d got set=%0b lock=%0b exp 0/0",
                         i, bus.pc_set, bus.mon_lock);
            end
        end
        quiet_inputs();
        checks += 2;
        if (bus.pc_set_adr !== last_adr) begin
            errors++;
            $display("FAIL idle_start_quit pc_set_adr got=%h exp=%h", bus.pc_set_adr, last_adr);
        end
        if (bus.stop_cause !== last_cause) begin
            errors++;
            $display("FAIL idle_start_quit stop_cause got=%0d exp=%0d", bus.stop_cause, last_cause);
        end
    endtask

    task automatic test_edge_cases();
        run_scenario("start_in_run", 30'h3000_0001, RUN0 + 7, -1, 1'b0, RUN0 + 2);
        run_scenario("quit_and_halt", 30'h0BEE, RUN0 + 6, RUN0 + 6, 1'b1, -1);
        run_scenario("quit_flush", 30'h0CAF, 3, -1, 1'b0, -1);
        run_scenario("halt_held", 30'h0D00, -1, 0, 1'b0, -1);
        run_scenario("quit_in_load", 30'h0E00, 1, RUN0 + 3, 1'b0, -1);
    endtask

    task automatic test_reset_mid_run();
        bus.cpu_start = 1'b1;
        bus.start_adr = 30'h0F0F;
        for (int t = 0; t < RUN0 + 3; t++) begin
            @(posedge clk);
            #1;
            quiet_inputs();
        end
        checks++;
        if (bus.cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre cpu_run got=%0b exp=1", bus.cpu_run);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.run_done !== 1'b0 || bus.mon_lock !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid hold cyc=%0d got done=%0b lock=%0b exp 0/0",
                         i, bus.run_done, bus.mon_lock);
            end
        end
        rst_n = 1'b1;
        run_scenario("after_rst", 30'h0A5A, RUN0 + 3, -1, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            int quit_t, halt_t;
            bit wen;
            wen    = 1'($urandom_range(0, 1));
            halt_t = -1;
            quit_t = -1;
            if ($urandom_range(0, 2) == 0) halt_t = int'($urandom_range(0, 30));
            if ($urandom_range(0, 1) == 1) quit_t = int'($urandom_range(1, 30));
            if (!wen && halt_t < 0 && quit_t < 2) quit_t = RUN0 + int'($urandom_range(0, 25));
            run_scenario($sformatf("rand%0d", k), 30'($urandom), quit_t, halt_t, wen,
                         ($urandom_range(0, 1) == 1) ? -2 : -1);
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_start_quit_idle();
        test_quit_run();
        test_watchdog();
        test_edge_cases();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
